full_adder_bist: RTL and testbench

//   Synchronous self-test controller for the lab full-adder cell: the hardware

---
 rtl/fa_pkg.sv | 18 +
 rtl/fa_golden.sv | 13 +
 rtl/full_adder_bist.sv | 137 +++++++++++++
 tb/tb_full_adder_bist.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fa_pkg.sv
// Shared definitions for the full-adder self-test controller and its golden model.
package fa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } fa_state_e;

  localparam int FA_VEC_W   = 3;
  localparam int FA_NUM_VEC = 8;

  function automatic logic fa_majority(input logic [FA_VEC_W-1:0] i_v);
    return (i_v[2] & i_v[1]) | (i_v[2] & i_v[0]) | (i_v[1] & i_v[0]);
  endfunction

endpackage

// File: rtl/fa_golden.sv
// Golden full-adder model: expected sum/cout for a {a,b,cin} vector.
module fa_golden
  import fa_pkg::*;
(
  input  logic [FA_VEC_W-1:0] i_vec,
  output logic                o_exp_sum,
  output logic                o_exp_cout
);

  assign o_exp_sum  = ^i_vec;
  assign o_exp_cout = fa_majority(i_vec);

endmodule

// File: rtl/full_adder_bist.sv
// Self-test controller: sweeps all {a,b,cin} vectors through an external full adder,
// compares each settled response against fa_golden and reports the outcome.
module full_adder_bist
  import fa_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_a,
  output logic             o_b,
  output logic             o_cin,
  input  logic             i_sum,
  input  logic             i_cout,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_count,
  output logic [2:0]       o_first_fail
);

  localparam int                  CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [FA_VEC_W-1:0] VEC_LAST = FA_VEC_W'(FA_NUM_VEC - 1);
  localparam logic [ERR_W-1:0]    ERR_MAX  = {ERR_W{1'b1}};

  fa_state_e           r_state, w_state_nxt;
  logic [FA_VEC_W-1:0] r_vec, w_vec_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [ERR_W-1:0]    r_err, w_err_nxt;
  logic [2:0]          r_first_fail, w_first_fail_nxt;
  logic                r_fail_seen, w_fail_seen_nxt;
  logic                r_busy, r_done, r_pass;
  logic                w_exp_sum, w_exp_cout, w_mismatch;

  fa_golden u_golden (
    .i_vec      (r_vec),
    .o_exp_sum  (w_exp_sum),
    .o_exp_cout (w_exp_cout)
  );

  assign w_mismatch = (i_sum != w_exp_sum) || (i_cout != w_exp_cout);

  always_comb begin
    w_state_nxt      = r_state;
    w_vec_nxt        = r_vec;
    w_cnt_nxt        = r_cnt;
    w_err_nxt        = r_err;
    w_first_fail_nxt = r_first_fail;
    w_fail_seen_nxt  = r_fail_seen;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state_nxt      = ST_SETTLE;
          w_vec_nxt        = {FA_VEC_W{1'b0}};
          w_cnt_nxt        = {CNT_W{1'b0}};
          w_err_nxt        = {ERR_W{1'b0}};
          w_first_fail_nxt = 3'b000;
          w_fail_seen_nxt  = 1'b0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1'b1);
        end
      end
      ST_SAMPLE: begin
        if (w_mismatch) begin
          w_err_nxt = (r_err == ERR_MAX) ? r_err : r_err + ERR_W'(1'b1);
          if (!r_fail_seen) begin
            w_first_fail_nxt = r_vec;
            w_fail_seen_nxt  = 1'b1;
          end else begin
            w_first_fail_nxt = r_first_fail;
          end
        end else begin
          w_err_nxt = r_err;
        end
        // last vector's check lands in the same cycle as the move to DONE
        if (r_vec == VEC_LAST) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_vec_nxt   = r_vec + FA_VEC_W'(1'b1);
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_state_nxt = ST_SETTLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vec        <= {FA_VEC_W{1'b0}};
      r_cnt        <= {CNT_W{1'b0}};
      r_err        <= {ERR_W{1'b0}};
      r_first_fail <= 3'b000;
      r_fail_seen  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_vec        <= w_vec_nxt;
      r_cnt        <= w_cnt_nxt;
      r_err        <= w_err_nxt;
      r_first_fail <= w_first_fail_nxt;
      r_fail_seen  <= w_fail_seen_nxt;
      r_busy       <= (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_SAMPLE);
      r_done       <= (w_state_nxt == ST_DONE);
      r_pass       <= (w_state_nxt == ST_DONE) && (w_err_nxt == {ERR_W{1'b0}});
    end
  end

  assign o_a          = r_vec[2];
  assign o_b          = r_vec[1];
  assign o_cin        = r_vec[0];
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_err_count  = r_err;
  assign o_first_fail = r_first_fail;

endmodule

// File: tb/tb_full_adder_bist.sv
// Directed bench: a behavioural full adder with injectable faults feeds two BIST instances.
module tb_full_adder_bist;

  logic       clk = 1'b0;
  logic       rst, start, start2;
  logic       a, b, cin, sum, cout, busy, done, pass;
  logic [3:0] err;
  logic [2:0] ff;
  logic       a2, b2, cin2, sum2, cout2, busy2, done2, pass2;
  logic [1:0] err2;
  logic [2:0] ff2;
  int         fault;
  int         n_total = 0;
  int         n_pass  = 0;
  int         cyc;

  always #5 clk = ~clk;

  // adder under test: 0 good, 1 sum stuck-at-0, 2 cout stuck-at-0
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
    case (fault)
      1:       sum  = 1'b0;
      2:       cout = 1'b0;
      default: ;
    endcase
  end

  assign sum2  = ~(a2 ^ b2 ^ cin2);
  assign cout2 = ~((a2 & b2) | (a2 & cin2) | (b2 & cin2));

  full_adder_bist #(.SETTLE_CYCLES(2), .ERR_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_a(a), .o_b(b), .o_cin(cin), .i_sum(sum), .i_cout(cout),
    .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_err_count(err), .o_first_fail(ff)
  );

  full_adder_bist #(.SETTLE_CYCLES(2), .ERR_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2),
    .o_a(a2), .o_b(b2), .o_cin(cin2), .i_sum(sum2), .i_cout(cout2),
    .o_busy(busy2), .o_done(done2), .o_pass(pass2),
    .o_err_count(err2), .o_first_fail(ff2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_done(input int pre, output int c);
    c = pre;
    while (!done && c < 200) begin
      step();
      c++;
    end
  endtask

  task automatic accept();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic sweep(output int c);
    accept();
    chk("accept_busy", busy, 1);
    chk("accept_done_clr", done, 0);
    chk("accept_err_clr", err, 0);
    chk("accept_ff_clr", ff, 0);
    run_to_done(0, c);
    chk("latency", c, 24);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; fault = 0;
    repeat (3) step();
    chk("rst_vec", {a, b, cin}, 3'b000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err, 0);
    chk("rst_ff", ff, 0);
    chk("rst2_err", err2, 0);
    rst = 1'b0;
    step();

    // good adder, vector order checked mid-settle of each vector
    accept();
    for (int c = 1; c <= 24; c++) begin
      step();
      if (c % 3 == 1) chk("vec_order", {a, b, cin}, (c - 1) / 3);
      if (c == 23) chk("busy_before_done", {busy, done}, 2'b10);
    end
    chk("good_done", done, 1);
    chk("good_pass", pass, 1);
    chk("good_err", err, 0);
    chk("good_ff", ff, 0);
    chk("good_busy", busy, 0);
    chk("good_vec_hold", {a, b, cin}, 3'b111);
    repeat (3) step();
    chk("done_held", {done, pass}, 2'b11);

    // sum stuck-at-0
    fault = 1;
    sweep(cyc);
    chk("s0_err", err, 4);
    chk("s0_ff", ff, 3'b001);
    chk("s0_pass", pass, 0);

    // cout stuck-at-0, restarted from DONE with a dirty result
    fault = 2;
    sweep(cyc);
    chk("c0_err", err, 4);
    chk("c0_ff", ff, 3'b011);
    chk("c0_pass", pass, 0);

    // start during SETTLE of vec 3 is ignored
    fault = 0;
    accept();
    repeat (9) step();
    chk("mid_vec3", {a, b, cin}, 3'b011);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("mid_ignore_vec", {a, b, cin}, 3'b011);
    chk("mid_ignore_busy", busy, 1);
    run_to_done(10, cyc);
    chk("mid_latency", cyc, 24);
    chk("mid_pass", pass, 1);

    // reset in SAMPLE of vec 5 with a sum fault
    fault = 1;
    accept();
    repeat (17) step();
    chk("pre_rst_vec", {a, b, cin}, 3'b101);
    chk("pre_rst_err", err, 3);
    chk("pre_rst_ff", ff, 3'b001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_vec", {a, b, cin}, 3'b000);
    chk("mrst_flags", {busy, done, pass}, 3'b000);
    chk("mrst_err", err, 0);
    chk("mrst_ff", ff, 0);
    step();
    chk("mrst_idle", {busy, done}, 2'b00);
    fault = 0;
    sweep(cyc);
    chk("fresh_pass", pass, 1);
    chk("fresh_err", err, 0);
    chk("fresh_ff", ff, 0);

    // inverted adder on a 2-bit counter saturates
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 200) begin
      step();
      cyc++;
    end
    chk("sat_latency", cyc, 24);
    chk("sat_err", err2, 3);
    chk("sat_ff", ff2, 3'b000);
    chk("sat_pass", pass2, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
